// File: rtl/candy_sram_ctrl.sv
// -----------------------------------------------------------------------------
// candy_sram_ctrl
//
// Single-outstanding request/response bridge onto a simple SRAM port.
// A request is accepted in IDLE, issued to the SRAM for exactly one cycle,
// reads then wait for the SRAM's rdata_ready pulse, and the response is held
// in RESP until the requester takes it. Every output is a flop loaded with
// the value belonging to the next state, so outputs change together with the
// state.
//
// Optional feature macro: CANDY_SRAM_TIMEOUT_EN
//   defined   : a read that sees no sram_rdata_ready within TIMEOUT_CYCLES
//               WAIT cycles completes with resp_err=1, resp_rdata=0.
//   undefined : WAIT waits indefinitely and resp_err is always 0.
//
// Widths come from candy_defines.v (`SRAMAddrWidth / `SRAMDataWidth);
// fallback values are provided so the block also builds stand-alone.
//
// Ports
//   clk, rst                 rising-edge clock, async active-low reset
//   req_valid/we/addr/wdata  request in;  req_ready out (high only in IDLE)
//   resp_valid/rdata/err     response out; resp_ready in
//   sram_write_enable/waddr/wdata, sram_read_enable/raddr   SRAM commands
//   sram_rdata, sram_rdata_ready                           SRAM read return
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef SRAMAddrWidth
`define SRAMAddrWidth 8
`endif
`ifndef SRAMDataWidth
`define SRAMDataWidth 8
`endif

module candy_sram_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  // requester side
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [`SRAMAddrWidth-1:0] req_addr,
  input  logic [`SRAMDataWidth-1:0] req_wdata,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [`SRAMDataWidth-1:0] resp_rdata,
  output logic                      resp_err,
  input  logic                      resp_ready,
  // SRAM side
  output logic                      sram_write_enable,
  output logic [`SRAMAddrWidth-1:0] sram_waddr,
  output logic [`SRAMDataWidth-1:0] sram_wdata,
  output logic                      sram_read_enable,
  output logic [`SRAMAddrWidth-1:0] sram_raddr,
  input  logic [`SRAMDataWidth-1:0] sram_rdata,
  input  logic                      sram_rdata_ready
);

  localparam int unsigned AW = `SRAMAddrWidth;
  localparam int unsigned DW = `SRAMDataWidth;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;            // direction of the transaction in flight
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            sram_we_q, sram_we_d;
  logic            sram_re_q, sram_re_d;
  logic [AW-1:0]   sram_waddr_q, sram_waddr_d;
  logic [DW-1:0]   sram_wdata_q, sram_wdata_d;
  logic [AW-1:0]   sram_raddr_q, sram_raddr_d;

`ifdef CANDY_SRAM_TIMEOUT_EN
  // Counts completed WAIT cycles 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    we_d         = we_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    sram_waddr_d = sram_waddr_q;
    sram_wdata_d = sram_wdata_q;
    sram_raddr_d = sram_raddr_q;
    // Enables default low so any command lasts exactly one cycle.
    sram_we_d    = 1'b0;
    sram_re_d    = 1'b0;
`ifdef CANDY_SRAM_TIMEOUT_EN
    cnt_d        = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d   = S_ISSUE;
          we_d      = req_we;
          // The SRAM commits a write only with both enables high.
          sram_re_d = 1'b1;
          sram_we_d = req_we;
          if (req_we) begin
            sram_waddr_d = req_addr;
            sram_wdata_d = req_wdata;
          end else begin
            sram_raddr_d = req_addr;
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // rdata_ready is only looked at here; pulses in other states are dropped.
        if (sram_rdata_ready) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = sram_rdata;
          resp_err_d   = 1'b0;
`ifdef CANDY_SRAM_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifndef CANDY_SRAM_TIMEOUT_EN
    resp_err_d = 1'b0;
`endif
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_re_q    <= 1'b0;
      sram_waddr_q <= '0;
      sram_wdata_q <= '0;
      sram_raddr_q <= '0;
`ifdef CANDY_SRAM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q      <= state_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      sram_we_q    <= sram_we_d;
      sram_re_q    <= sram_re_d;
      sram_waddr_q <= sram_waddr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_raddr_q <= sram_raddr_d;
`ifdef CANDY_SRAM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_err          = resp_err_q;
  assign sram_write_enable = sram_we_q;
  assign sram_read_enable  = sram_re_q;
  assign sram_waddr        = sram_waddr_q;
  assign sram_wdata        = sram_wdata_q;
  assign sram_raddr        = sram_raddr_q;

endmodule

// File: tb/tb_candy_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_candy_sram_ctrl
//
// Directed bench for candy_sram_ctrl. Inputs change and outputs are sampled
// 1 ns after the rising edge; the value seen there is what the next edge will
// sample. Timeout cases are selected by CANDY_SRAM_TIMEOUT_EN like the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef SRAMAddrWidth
`define SRAMAddrWidth 8
`endif
`ifndef SRAMDataWidth
`define SRAMDataWidth 8
`endif

module tb_candy_sram_ctrl;

  localparam int unsigned AW = `SRAMAddrWidth;
  localparam int unsigned DW = `SRAMDataWidth;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          resp_ready = 1'b1;
  logic          sram_write_enable;
  logic [AW-1:0] sram_waddr;
  logic [DW-1:0] sram_wdata;
  logic          sram_read_enable;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;
  logic          sram_rdata_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  candy_sram_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .resp_ready        (resp_ready),
    .sram_write_enable (sram_write_enable),
    .sram_waddr        (sram_waddr),
    .sram_wdata        (sram_wdata),
    .sram_read_enable  (sram_read_enable),
    .sram_raddr        (sram_raddr),
    .sram_rdata        (sram_rdata),
    .sram_rdata_ready  (sram_rdata_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, confirm it is acceptable, let the accept edge pass.
  task automatic accept(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    check("accept_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_enables",    {30'd0, sram_write_enable, sram_read_enable}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    check("rst_rel_req_ready_lo", 32'(req_ready), 32'd0);
    tick();
    check("rst_rel_req_ready_hi", 32'(req_ready), 32'd1);

    // ---------------- write 0x05 <- 0xA5 ----------------
    resp_ready = 1'b1;
    accept(1'b1, 8'h05, 8'hA5);
    check("wr_we",        32'(sram_write_enable), 32'd1);
    check("wr_re",        32'(sram_read_enable),  32'd1);
    check("wr_waddr",     32'(sram_waddr),        32'h05);
    check("wr_wdata",     32'(sram_wdata),        32'hA5);
    check("wr_req_ready", 32'(req_ready),         32'd0);
    tick();
    check("wr_en_drop",   {30'd0, sram_write_enable, sram_read_enable}, 32'd0);
    check("wr_valid",     32'(resp_valid), 32'd1);
    check("wr_rdata",     32'(resp_rdata), 32'd0);
    check("wr_err",       32'(resp_err),   32'd0);
    tick();
    check("wr_done_valid", 32'(resp_valid), 32'd0);
    check("wr_done_ready", 32'(req_ready),  32'd1);

    // ---------------- read 0x05 -> 0xA5 ----------------
    accept(1'b0, 8'h05, 8'h00);
    check("rd_re",    32'(sram_read_enable),  32'd1);
    check("rd_we",    32'(sram_write_enable), 32'd0);
    check("rd_raddr", 32'(sram_raddr),        32'h05);
    tick();
    check("rd_wait_re",    32'(sram_read_enable), 32'd0);
    check("rd_wait_valid", 32'(resp_valid),       32'd0);
    sram_rdata_ready = 1'b1;
    sram_rdata       = 8'hA5;
    tick();
    sram_rdata_ready = 1'b0;
    check("rd_valid", 32'(resp_valid), 32'd1);
    check("rd_rdata", 32'(resp_rdata), 32'hA5);
    check("rd_err",   32'(resp_err),   32'd0);
    tick();
    check("rd_done_ready", 32'(req_ready), 32'd1);

    // ---------------- back-pressure, requests ignored ----------------
    resp_ready = 1'b0;
    accept(1'b0, 8'h11, 8'h00);
    tick();
    sram_rdata_ready = 1'b1;
    sram_rdata       = 8'h5A;
    tick();
    sram_rdata_ready = 1'b0;
    req_valid = 1'b1;  // must not be taken while busy
    req_we    = 1'b1;
    req_addr  = 8'h22;
    req_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",     32'(resp_valid), 32'd1);
      check("bp_rdata",     32'(resp_rdata), 32'h5A);
      check("bp_req_ready", 32'(req_ready),  32'd0);
      check("bp_no_cmd",    {30'd0, sram_write_enable, sram_read_enable}, 32'd0);
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready),  32'd1);

    // ---------------- stray rdata_ready in IDLE ----------------
    sram_rdata_ready = 1'b1;
    sram_rdata       = 8'h3C;
    tick();
    sram_rdata_ready = 1'b0;
    check("stray_rdata",     32'(resp_rdata), 32'h5A);
    check("stray_valid",     32'(resp_valid), 32'd0);
    check("stray_req_ready", 32'(req_ready),  32'd1);
    tick();
    check("stray_no_cmd", {30'd0, sram_write_enable, sram_read_enable}, 32'd0);

`ifdef CANDY_SRAM_TIMEOUT_EN
    // ---------------- timeout: no ready for TO WAIT cycles ----------------
    accept(1'b0, 8'h30, 8'h00);
    tick();  // now in WAIT
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("to_wait_valid", 32'(resp_valid), 32'd0);
    end
    tick();
    check("to_valid", 32'(resp_valid), 32'd1);
    check("to_err",   32'(resp_err),   32'd1);
    check("to_rdata", 32'(resp_rdata), 32'd0);
    tick();

    // ---------------- ready on the final counted cycle wins ----------------
    accept(1'b0, 8'h31, 8'h00);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    sram_rdata_ready = 1'b1;
    sram_rdata       = 8'h77;
    tick();
    sram_rdata_ready = 1'b0;
    check("edge_valid", 32'(resp_valid), 32'd1);
    check("edge_err",   32'(resp_err),   32'd0);
    check("edge_rdata", 32'(resp_rdata), 32'h77);
    tick();
    // leave a non-zero value to observe the async clear
    accept(1'b0, 8'h40, 8'h00);
    tick();
`else
    // ---------------- no timeout: WAIT holds indefinitely ----------------
    begin
      int seen = 0;
      accept(1'b0, 8'h40, 8'h00);
      tick();
      for (int i = 0; i < 100; i++) begin
        tick();
        if (resp_valid) seen++;
      end
      check("noto_valid_count", 32'(seen), 32'd0);
      check("noto_err",         32'(resp_err), 32'd0);
    end
`endif

    // ---------------- async reset while in WAIT ----------------
    check("pre_rst_raddr", 32'(sram_raddr), 32'h40);
    #2 rst = 1'b0;
    #1;
    check("arst_valid",     32'(resp_valid), 32'd0);
    check("arst_rdata",     32'(resp_rdata), 32'd0);
    check("arst_raddr",     32'(sram_raddr), 32'd0);
    check("arst_waddr",     32'(sram_waddr), 32'd0);
    check("arst_wdata",     32'(sram_wdata), 32'd0);
    check("arst_req_ready", 32'(req_ready),  32'd0);
    tick();
    rst = 1'b1;
    sram_rdata_ready = 1'b1;  // late return from the abandoned read
    sram_rdata       = 8'h99;
    tick();
    sram_rdata_ready = 1'b0;
    check("post_rst_valid", 32'(resp_valid), 32'd0);
    check("post_rst_rdata", 32'(resp_rdata), 32'd0);
    check("post_rst_ready", 32'(req_ready),  32'd1);
    accept(1'b0, 8'h06, 8'h00);
    check("post_rst_raddr", 32'(sram_raddr), 32'h06);
    tick();
    sram_rdata_ready = 1'b1;
    sram_rdata       = 8'h42;
    tick();
    sram_rdata_ready = 1'b0;
    check("post_rst_rd_valid", 32'(resp_valid), 32'd1);
    check("post_rst_rd_rdata", 32'(resp_rdata), 32'h42);
    check("post_rst_rd_err",   32'(resp_err),   32'd0);
    tick();
    check("post_rst_idle", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/candy_sram_ctrl.md
CANDY_SRAM_CTRL -- requirements
Module: candy_sram_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the read-wait cycle budget; it is used only when CANDY_SRAM_TIMEOUT_EN is defined.
REQ-002 Widths SHALL come from candy_defines.v: `SRAMAddrWidth for addresses and `SRAMDataWidth for data.
REQ-003 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-004 Requester-side request ports SHALL be:
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  addr  target address.
- req_wdata  in  data  write data.
- req_ready  out  1  controller can accept a request.
REQ-005 Requester-side response ports SHALL be:
- resp_valid  out  1  response present.
- resp_rdata  out  data  read data; 0 for writes.
- resp_err  out  1  read timed out.
- resp_ready  in  1  requester accepts the response.
REQ-006 SRAM-side ports SHALL be:
- sram_write_enable  out  1.
- sram_waddr  out  addr.
- sram_wdata  out  data.
- sram_read_enable  out  1.
- sram_raddr  out  addr.
- sram_rdata  in  data.
- sram_rdata_ready  in  1  one-cycle pulse, rdata valid.

Function
REQ-007 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; every output SHALL be registered.
REQ-008 In IDLE, req_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-009 A handshake (req_valid && req_ready) SHALL latch req_we, req_addr and req_wdata, then go to ISSUE.
REQ-010 In ISSUE, for a write, the block SHALL drive sram_write_enable=1 and sram_read_enable=1 together for exactly one cycle, with waddr=addr and wdata=data, then go to RESP.
- The SRAM commits a write only when both enables are high.
REQ-011 In ISSUE, for a read, the block SHALL drive sram_read_enable=1 and sram_write_enable=0 for exactly one cycle, with raddr=addr, then go to WAIT.
REQ-012 In WAIT, both SRAM enables SHALL be 0; when sram_rdata_ready=1, the block SHALL capture sram_rdata into resp_rdata and go to RESP.
REQ-013 In RESP, resp_valid SHALL be held at 1, with resp_rdata and resp_err stable, until resp_ready=1; the block SHALL then return to IDLE.
REQ-014 Latency with resp_ready held at 1:
- Write: resp_valid SHALL assert 2 cycles after the accept edge.
- Read: resp_valid SHALL assert 3 cycles after the accept edge.
- Throughput: 1 request per 3 cycles (write) or 4 cycles (read).
REQ-015 A sram_rdata_ready pulse outside WAIT SHALL be ignored; it SHALL NOT alter resp_rdata or the state.
REQ-016 Request inputs SHALL be ignored while req_ready=0; no queuing.
REQ-017 In RESP, resp_rdata SHALL be 0 and resp_err SHALL be 0 for writes.

Reset
REQ-018 rst=0 SHALL immediately force:
- state to IDLE;
- all SRAM enables, addresses and wdata to 0;
- resp_valid, resp_rdata and resp_err to 0;
- the timeout counter to 0.
REQ-019 req_ready SHALL reset to 0 and SHALL become 1 on the first clk edge after rst deasserts.
REQ-020 Reset during WAIT or RESP SHALL abandon the transaction; a later stray sram_rdata_ready SHALL be ignored per REQ-015.

Configuration
REQ-021 With CANDY_SRAM_TIMEOUT_EN defined, a counter SHALL run in WAIT.
- If sram_rdata_ready has not arrived after TIMEOUT_CYCLES WAIT cycles, the block SHALL go to RESP with resp_err=1 and resp_rdata=0.
- If ready arrives on the final counted cycle, it SHALL win, giving resp_err=0.
REQ-022 Without CANDY_SRAM_TIMEOUT_EN, there SHALL be no counter, WAIT SHALL wait indefinitely, and resp_err SHALL be tied to 0.

Verification
REQ-023 Write, addr=0x05, data=0xA5, resp_ready=1 -> one cycle with both enables=1, waddr=0x05, wdata=0xA5; resp_valid=1 at accept+2, resp_rdata=0, resp_err=0.
REQ-024 Read, addr=0x05, SRAM model pulses ready with 0xA5 at accept+2 -> sram_read_enable=1 only at accept+1; resp_valid=1 at accept+3 with resp_rdata=0xA5.
REQ-025 resp_ready held 0 for 5 cycles after resp_valid -> resp_valid and data are stable and req_ready=0 throughout; the block returns to IDLE on the cycle after resp_ready=1.
REQ-026 sram_rdata_ready=1 with 0x3C while IDLE -> no state change and resp_rdata unchanged.
REQ-027 Macro defined, TIMEOUT_CYCLES=4, ready never returned -> resp_err=1 and resp_rdata=0 after 4 WAIT cycles; macro undefined -> resp_valid stays 0 for 100 cycles.
REQ-028 rst=0 asserted in WAIT -> outputs are zero without a clock edge; after release, a new read completes normally.
